// File: rtl/frame_rx_param.sv
// Oversampling serial frame receiver: start, DEST, SRC, DATA, CRC-8, stop (MSB first).
// Define FRAME_RX_BCAST_EN to accept an all-ones DEST as broadcast and flag it on bcast.
module frame_rx_param #(
    parameter int unsigned ID_W         = 4,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic [ID_W-1:0]   node_id,
    output logic              rx_valid,
    output logic [ID_W-1:0]   source_id,
    output logic [DATA_W-1:0] dout,
    output logic              crc_err,
    output logic              frame_err,
`ifdef FRAME_RX_BCAST_EN
    output logic              bcast,
`endif
    output logic              busy
);
    localparam int unsigned L     = 2 * ID_W + DATA_W + 8;
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(L + 1);

    localparam logic [CNT_W-1:0] SAMPLE   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(L - 1);
    localparam logic [BIT_W-1:0] CRC_BITS = BIT_W'(L - 8);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] START   = 2'd1;
    localparam logic [1:0] RECEIVE = 2'd2;
    localparam logic [1:0] STOP    = 2'd3;

    logic              din_s1_q, line_q, line_prev_q;
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [L-1:0]      shreg_q, shreg_d;
    logic [7:0]        crc_q, crc_d;
    logic              rx_valid_q, rx_valid_d;
    logic              crc_err_q, crc_err_d;
    logic              frame_err_q, frame_err_d;
    logic [ID_W-1:0]   source_id_q, source_id_d;
    logic [DATA_W-1:0] dout_q, dout_d;
`ifdef FRAME_RX_BCAST_EN
    logic              bcast_q, bcast_d;
`endif

    logic            sample;
    logic            crc_fb;
    logic            crc_bad;
    logic            dest_hit;
    logic [ID_W-1:0] dest;

    assign sample  = (cnt_q == SAMPLE);
    assign crc_fb  = crc_q[7] ^ line_q;
    assign dest    = shreg_q[L-1 -: ID_W];
    assign crc_bad = (shreg_q[7:0] != crc_q);
`ifdef FRAME_RX_BCAST_EN
    assign dest_hit = (dest == node_id) || (&dest);
`else
    assign dest_hit = (dest == node_id);
`endif

    always_comb begin
        state_d     = state_q;
        // Counter wraps at every bit boundary so the sample point stays mid-bit.
        cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        crc_d       = crc_q;
        rx_valid_d  = 1'b0;
        crc_err_d   = 1'b0;
        frame_err_d = 1'b0;
        source_id_d = source_id_q;
        dout_d      = dout_q;
`ifdef FRAME_RX_BCAST_EN
        bcast_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (line_prev_q && !line_q) begin
                    state_d   = START;
                    bit_cnt_d = '0;
                    crc_d     = 8'h00;
                end
            end
            START: begin
                if (sample) begin
                    state_d = line_q ? IDLE : RECEIVE;
                end
            end
            RECEIVE: begin
                if (sample) begin
                    shreg_d   = {shreg_q[L-2:0], line_q};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q < CRC_BITS) begin
                        crc_d = {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
                    end
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (sample) begin
                    state_d     = IDLE;
                    frame_err_d = !line_q;
                    crc_err_d   = crc_bad;
                    if (line_q && !crc_bad && dest_hit) begin
                        rx_valid_d  = 1'b1;
                        source_id_d = shreg_q[L-1-ID_W -: ID_W];
                        dout_d      = shreg_q[8 +: DATA_W];
`ifdef FRAME_RX_BCAST_EN
                        bcast_d     = &dest;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_s1_q    <= 1'b1;
            line_q      <= 1'b1;
            line_prev_q <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            crc_q       <= 8'h00;
            rx_valid_q  <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            source_id_q <= '0;
            dout_q      <= '0;
`ifdef FRAME_RX_BCAST_EN
            bcast_q     <= 1'b0;
`endif
        end else begin
            din_s1_q    <= din;
            line_q      <= din_s1_q;
            line_prev_q <= line_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            crc_q       <= crc_d;
            rx_valid_q  <= rx_valid_d;
            crc_err_q   <= crc_err_d;
            frame_err_q <= frame_err_d;
            source_id_q <= source_id_d;
            dout_q      <= dout_d;
`ifdef FRAME_RX_BCAST_EN
            bcast_q     <= bcast_d;
`endif
        end
    end

    assign rx_valid  = rx_valid_q;
    assign crc_err   = crc_err_q;
    assign frame_err = frame_err_q;
    assign source_id = source_id_q;
    assign dout      = dout_q;
    assign busy      = (state_q != IDLE);
`ifdef FRAME_RX_BCAST_EN
    assign bcast     = bcast_q;
`endif

endmodule

// File: tb/tb_frame_rx_param.sv
// Scoreboard bench for frame_rx_param: default instance (a) and a wide instance (b).
module tb_frame_rx_param;
    localparam int IDA = 4, DWA = 8, CPBA = 8, LA = 2 * IDA + DWA + 8;
    localparam int IDB = 6, DWB = 16, CPBB = 16, LB = 2 * IDB + DWB + 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din_a = 1'b1;
    logic din_b = 1'b1;
    logic [IDA-1:0] node_a = 4'h5;
    logic [IDB-1:0] node_b = 6'h12;

    logic           rx_valid_a, crc_err_a, frame_err_a, busy_a;
    logic [IDA-1:0] source_id_a;
    logic [DWA-1:0] dout_a;
    logic           rx_valid_b, crc_err_b, frame_err_b, busy_b;
    logic [IDB-1:0] source_id_b;
    logic [DWB-1:0] dout_b;
`ifdef FRAME_RX_BCAST_EN
    logic           bcast_a, bcast_b;
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    frame_rx_param #(.ID_W(IDA), .DATA_W(DWA), .CLKS_PER_BIT(CPBA)) u_dut_a (
        .clk(clk), .rst(rst), .din(din_a), .node_id(node_a),
        .rx_valid(rx_valid_a), .source_id(source_id_a), .dout(dout_a),
        .crc_err(crc_err_a), .frame_err(frame_err_a),
`ifdef FRAME_RX_BCAST_EN
        .bcast(bcast_a),
`endif
        .busy(busy_a)
    );

    frame_rx_param #(.ID_W(IDB), .DATA_W(DWB), .CLKS_PER_BIT(CPBB)) u_dut_b (
        .clk(clk), .rst(rst), .din(din_b), .node_id(node_b),
        .rx_valid(rx_valid_b), .source_id(source_id_b), .dout(dout_b),
        .crc_err(crc_err_b), .frame_err(frame_err_b),
`ifdef FRAME_RX_BCAST_EN
        .bcast(bcast_b),
`endif
        .busy(busy_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind = {rx_valid, crc_err, frame_err}; at = cycle of the expected pulse
    typedef struct {
        logic [2:0]  kind;
        logic [31:0] src;
        logic [31:0] data;
        logic        bc;
        int          at;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] crc8(input logic [63:0] v, input int n);
        logic [7:0] c;
        c = 8'h00;
        for (int i = n - 1; i >= 0; i--) begin
            if (c[7] ^ v[i]) c = {c[6:0], 1'b0} ^ 8'h07;
            else             c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    always @(negedge clk) begin
        if (!rst && (rx_valid_a || crc_err_a || frame_err_a)) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected: got v/c/f=%b%b%b, required no pulse (cycle %0d)",
                         rx_valid_a, crc_err_a, frame_err_a, cyc);
            end else begin
                ea = q_a.pop_front();
                chk("a_flags", 64'({rx_valid_a, crc_err_a, frame_err_a}), 64'(ea.kind));
                chk("a_latency", 64'(cyc), 64'(ea.at));
                if (ea.kind == 3'b100) begin
                    chk("a_source_id", 64'(source_id_a), 64'(ea.src));
                    chk("a_dout", 64'(dout_a), 64'(ea.data));
`ifdef FRAME_RX_BCAST_EN
                    chk("a_bcast", 64'(bcast_a), 64'(ea.bc));
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && (rx_valid_b || crc_err_b || frame_err_b)) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected: got v/c/f=%b%b%b, required no pulse (cycle %0d)",
                         rx_valid_b, crc_err_b, frame_err_b, cyc);
            end else begin
                eb = q_b.pop_front();
                chk("b_flags", 64'({rx_valid_b, crc_err_b, frame_err_b}), 64'(eb.kind));
                chk("b_latency", 64'(cyc), 64'(eb.at));
                if (eb.kind == 3'b100) begin
                    chk("b_source_id", 64'(source_id_b), 64'(eb.src));
                    chk("b_dout", 64'(dout_b), 64'(eb.data));
`ifdef FRAME_RX_BCAST_EN
                    chk("b_bcast", 64'(bcast_b), 64'(eb.bc));
`endif
                end
            end
        end
    end

    // Drives the first ndrive of nb frame bits MSB first; pulse expected 2 sync + 2 edge-detect
    // cycles plus half a bit after the stop-bit start.
    task automatic send(input int u, input logic [63:0] fr, input int nb, input int ndrive,
                        input int cpb, input exp_t e);
        @(negedge clk);
        e.at = cyc + 4 + cpb / 2 - 1 + (nb - 1) * cpb;
        if (e.kind != 3'b000) begin
            if (u == 0) q_a.push_back(e);
            else        q_b.push_back(e);
        end
        for (int i = nb - 1; i >= nb - ndrive; i--) begin
            if (u == 0) din_a = fr[i];
            else        din_b = fr[i];
            repeat (cpb) @(negedge clk);
        end
        if (ndrive == nb) begin
            if (u == 0) din_a = 1'b1;
            else        din_b = 1'b1;
        end
    endtask

    task automatic send_a(input logic [3:0] dest, input logic [3:0] src, input logic [7:0] data,
                          input logic [7:0] cx, input logic stp, input logic [2:0] kind,
                          input int ndrive);
        logic [63:0] fr;
        exp_t e;
        fr = 64'({1'b0, dest, src, data, crc8(64'({dest, src, data}), 16) ^ cx, stp});
        e.kind = kind; e.src = 32'(src); e.data = 32'(data); e.bc = 1'b0; e.at = 0;
        send(0, fr, LA + 2, ndrive, CPBA, e);
    endtask

    task automatic send_b(input logic [5:0] dest, input logic [5:0] src, input logic [15:0] data,
                          input logic [2:0] kind, input logic bc);
        logic [63:0] fr;
        exp_t e;
        fr = 64'({1'b0, dest, src, data, crc8(64'({dest, src, data}), 28), 1'b1});
        e.kind = kind; e.src = 32'(src); e.data = 32'(data); e.bc = bc; e.at = 0;
        send(1, fr, LB + 2, LB + 2, CPBB, e);
    endtask

    task automatic settle_a(input string name);
        repeat (2 * CPBA) @(negedge clk);
        chk(name, 64'(q_a.size()), 64'd0);
        chk({name, "_busy"}, 64'(busy_a), 64'd0);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_rx_valid", 64'(rx_valid_a), 64'd0);
        chk("rst_errs", 64'({crc_err_a, frame_err_a}), 64'd0);
        chk("rst_source_id", 64'(source_id_a), 64'd0);
        chk("rst_dout", 64'(dout_a), 64'd0);
        chk("rst_busy", 64'({busy_a, busy_b}), 64'd0);
        chk("rst_dout_b", 64'(dout_b), 64'd0);
`ifdef FRAME_RX_BCAST_EN
        chk("rst_bcast", 64'({bcast_a, bcast_b}), 64'd0);
`endif
        rst = 1'b0;
        repeat (4) @(negedge clk);

        send_a(4'h5, 4'hA, 8'h3C, 8'h00, 1'b1, 3'b100, LA + 2);
        settle_a("valid_pending");

        // Different SRC/DATA so a wrongful load on a dropped frame would be visible.
        send_a(4'h3, 4'h7, 8'h99, 8'h00, 1'b1, 3'b000, LA + 2);
        settle_a("drop_pending");
        chk("drop_hold_source_id", 64'(source_id_a), 64'hA);
        chk("drop_hold_dout", 64'(dout_a), 64'h3C);

        send_a(4'h5, 4'hA, 8'h3C, 8'h01, 1'b1, 3'b010, LA + 2);
        settle_a("crc_pending");

        send_a(4'h5, 4'hA, 8'h3C, 8'h00, 1'b0, 3'b001, LA + 2);
        repeat (CPBA) @(negedge clk);
        send_a(4'h5, 4'h6, 8'hA5, 8'h00, 1'b1, 3'b100, LA + 2);
        settle_a("b2b_pending");

        send_a(4'h5, 4'hA, 8'h3C, 8'h80, 1'b0, 3'b011, LA + 2);
        settle_a("both_pending");

        din_a = 1'b0;
        repeat (2) @(negedge clk);
        din_a = 1'b1;
        repeat (2) @(negedge clk);
        chk("glitch_busy_high", 64'(busy_a), 64'd1);
        settle_a("glitch_pending");

        // Start + header + 4 DATA bits, then reset while the frame is in flight.
        send_a(4'h5, 4'hA, 8'h3C, 8'h00, 1'b1, 3'b000, 1 + 2 * IDA + 4);
        chk("midframe_busy", 64'(busy_a), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy_a), 64'd0);
        chk("midrst_flags", 64'({rx_valid_a, crc_err_a, frame_err_a}), 64'd0);
        chk("midrst_source_id", 64'(source_id_a), 64'd0);
        chk("midrst_dout", 64'(dout_a), 64'd0);
        din_a = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        send_a(4'h5, 4'hC, 8'h81, 8'h00, 1'b1, 3'b100, LA + 2);
        settle_a("post_rst_pending");

        // Wide instance: all-ones DEST is accepted by a foreign node only when broadcast exists.
        send_b(6'h3F, 6'h2A, 16'hBEEF, BC ? 3'b100 : 3'b000, BC);
        repeat (2 * CPBB) @(negedge clk);
        chk("b_bcast_pending", 64'(q_b.size()), 64'd0);
        node_b = 6'h3F;
        send_b(6'h3F, 6'h15, 16'hBEEF, 3'b100, BC);
        repeat (2 * CPBB) @(negedge clk);
        chk("b_ones_pending", 64'(q_b.size()), 64'd0);
        node_b = 6'h12;
        send_b(6'h12, 6'h01, 16'h1234, 3'b100, 1'b0);
        repeat (2 * CPBB) @(negedge clk);
        chk("b_unicast_pending", 64'(q_b.size()), 64'd0);
        chk("b_busy", 64'(busy_b), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
